// File: rtl/draw_pkg.sv
// Shared types, default geometry and helpers for the layer draw engine.
package draw_pkg;

  localparam int DEF_FB_WIDTH   = 320;
  localparam int DEF_FB_HEIGHT  = 240;
  localparam int DEF_COLOR_BITS = 9;

  typedef enum logic [1:0] {
    DRAW,
    SWAP_WAIT,
    CLEAR
  } fbw_state_t;

  // Increment a 16-bit event counter by one, holding at full scale.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
    return (inc && (value != 16'hFFFF)) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/fb_addr_pipe.sv
// Two-stage pixel pipeline: stage 1 clips and forms y*FB_WIDTH, stage 2 adds x
// and presents the framebuffer write address, colour and valid.
module fb_addr_pipe
  import draw_pkg::*;
#(
  parameter int FB_WIDTH   = DEF_FB_WIDTH,
  parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int ADDR_W     = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_en,
  input  logic [31:0]           in_x,
  input  logic [31:0]           in_y,
  input  logic [COLOR_BITS-1:0] in_color,
  output logic                  clip,
  output logic                  s1_valid,
  output logic                  out_valid,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [COLOR_BITS-1:0] out_color
);

  localparam logic [31:0] WIDTH_32  = 32'(FB_WIDTH);
  localparam logic [31:0] HEIGHT_32 = 32'(FB_HEIGHT);

  logic                  in_range;
  logic [ADDR_W-1:0]     x_q;
  logic [ADDR_W-1:0]     row_q;
  logic [COLOR_BITS-1:0] color_q;

  // Unsigned compare, so wrapped negative coordinates fall outside the frame.
  assign in_range = (in_x < WIDTH_32) && (in_y < HEIGHT_32);
  assign clip     = in_en && !in_range;

  // Stage 1: capture an in-frame pixel and its row base address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      x_q      <= '0;
      row_q    <= '0;
      color_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, independent of order.
      s1_valid <= in_en && in_range;
      if (in_en && in_range) begin
        x_q     <= in_x[ADDR_W-1:0];
        row_q   <= in_y[ADDR_W-1:0] * ADDR_W'(FB_WIDTH);
        color_q <= in_color;
      end
    end
  end

  // Stage 2: final linear address; data only moves when a pixel is present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_color <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_addr  <= row_q + x_q;
        out_color <= color_q;
      end
    end
  end

endmodule

// File: rtl/draw_fb_writer.sv
// Framebuffer writer: clips the draw engine's pixel stream into back-bank
// writes, swaps banks on vertical blank after a request, then clears the new
// back bank.
module draw_fb_writer
  import draw_pkg::*;
#(
  parameter int                    FB_WIDTH    = DEF_FB_WIDTH,
  parameter int                    FB_HEIGHT   = DEF_FB_HEIGHT,
  parameter int                    COLOR_BITS  = DEF_COLOR_BITS,
  parameter int                    ADDR_W      = 17,
  parameter bit                    CLEAR_EN    = 1'b1,
  parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           draw_x,
  input  logic [31:0]           draw_y,
  input  logic [31:0]           draw_color,
  input  logic                  draw_en,
  input  logic                  swap_req,
  input  logic                  vblank,
  output logic                  fb_we,
  output logic                  fb_wbank,
  output logic [ADDR_W-1:0]     fb_waddr,
  output logic [COLOR_BITS-1:0] fb_wdata,
  output logic                  front_sel,
  output logic                  busy,
  output logic [15:0]           clip_count,
  output logic [15:0]           drop_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  fbw_state_t            state;
  fbw_state_t            state_nxt;
  logic                  vblank_q;
  logic                  vbl_pend;
  logic                  swap_fire;
  logic [ADDR_W-1:0]     clear_addr;
  logic                  pipe_clip;
  logic                  pipe_s1_valid;
  logic                  pipe_we;
  logic [ADDR_W-1:0]     pipe_addr;
  logic [COLOR_BITS-1:0] pipe_color;
  logic                  unused_color_hi;

  assign unused_color_hi = ^draw_color[31:COLOR_BITS];

  fb_addr_pipe #(
    .FB_WIDTH   (FB_WIDTH),
    .FB_HEIGHT  (FB_HEIGHT),
    .COLOR_BITS (COLOR_BITS),
    .ADDR_W     (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_en     (draw_en && (state == DRAW)),
    .in_x      (draw_x),
    .in_y      (draw_y),
    .in_color  (draw_color[COLOR_BITS-1:0]),
    .clip      (pipe_clip),
    .s1_valid  (pipe_s1_valid),
    .out_valid (pipe_we),
    .out_addr  (pipe_addr),
    .out_color (pipe_color)
  );

  // The swap waits for a latched vblank edge and an empty pipeline, so no
  // in-flight pixel can land in the bank that is about to be displayed.
  assign swap_fire = (state == SWAP_WAIT) && vbl_pend && !pipe_s1_valid && !pipe_we;
  assign fb_wbank  = ~front_sel;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DRAW;
    else       state <= state_nxt;
  end

  // Next state and the write-port mux between pipeline and clear engine.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    state_nxt = state;
    busy      = (state != DRAW);
    fb_we     = pipe_we;
    fb_waddr  = pipe_addr;
    fb_wdata  = pipe_color;
    case (state)
      DRAW: begin
        if (swap_req) state_nxt = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        if (swap_fire) state_nxt = CLEAR_EN ? CLEAR : DRAW;
      end
      CLEAR: begin
        fb_we    = 1'b1;
        fb_waddr = clear_addr;
        fb_wdata = CLEAR_COLOR;
        if (clear_addr == LAST_ADDR) state_nxt = DRAW;
      end
      default: state_nxt = DRAW;
    endcase
  end

  // Bank select, vblank edge capture and the pending-swap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_sel <= 1'b0;
      vblank_q  <= 1'b0;
      vbl_pend  <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (swap_fire) begin
        front_sel <= ~front_sel;
        vbl_pend  <= 1'b0;
      end else if ((state == SWAP_WAIT) && vblank && !vblank_q) begin
        vbl_pend <= 1'b1;
      end
    end
  end

  // Clear address walks the whole visible area once per swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_addr <= '0;
    end else if (swap_fire) begin
      clear_addr <= '0;
    end else if (state == CLEAR) begin
      clear_addr <= clear_addr + 1'b1;
    end
  end

  // Saturating statistics for clipped and dropped pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_count <= '0;
      drop_count <= '0;
    end else begin
      clip_count <= sat_inc16(clip_count, pipe_clip);
      drop_count <= sat_inc16(drop_count, draw_en && (state != DRAW));
    end
  end

endmodule

// File: tb/tb_draw_fb_writer.sv
// Randomized bench for draw_fb_writer: a queue of expected framebuffer writes
// built from the clip/address/bank rules, plus a small second instance
// (16x8, no clear) used for counter saturation and the direct swap path.
module tb_draw_fb_writer;

  localparam int W = 320;
  localparam int H = 240;
  localparam int NPIX = W * H;

  typedef logic [26:0] wr_t;  // {bank, addr[16:0], colour[8:0]}

  logic        clk = 1'b0;
  logic        reset, reset_b;
  logic [31:0] draw_x, draw_y, draw_color;
  logic        draw_en, swap_req, vblank;
  logic        fb_we, fb_wbank, front_sel, busy;
  logic [16:0] fb_waddr;
  logic [8:0]  fb_wdata;
  logic [15:0] clip_count, drop_count;

  logic [31:0] bx, by, bcolor;
  logic        ben, bswap, bvblank;
  logic        b_we, b_wbank, b_front, b_busy;
  logic [6:0]  b_waddr;
  logic [8:0]  b_wdata;
  logic [15:0] b_clip, b_drop;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  bit  m_front;
  bit  m_accept;
  int  m_clip, m_drop;
  int  b_writes;
  logic [16:0] b_last;

  always #5 clk = ~clk;

  draw_fb_writer dut (
    .clk(clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
    .draw_color(draw_color), .draw_en(draw_en), .swap_req(swap_req),
    .vblank(vblank), .fb_we(fb_we), .fb_wbank(fb_wbank), .fb_waddr(fb_waddr),
    .fb_wdata(fb_wdata), .front_sel(front_sel), .busy(busy),
    .clip_count(clip_count), .drop_count(drop_count)
  );

  draw_fb_writer #(.FB_WIDTH(16), .FB_HEIGHT(8), .ADDR_W(7), .CLEAR_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .draw_x(bx), .draw_y(by),
    .draw_color(bcolor), .draw_en(ben), .swap_req(bswap),
    .vblank(bvblank), .fb_we(b_we), .fb_wbank(b_wbank), .fb_waddr(b_waddr),
    .fb_wdata(b_wdata), .front_sel(b_front), .busy(b_busy),
    .clip_count(b_clip), .drop_count(b_drop)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write of the main instance must be the next one the model expects.
  always @(negedge clk) begin
    if (!reset && fb_we) begin
      if (exp_q.size() == 0) check("spurious_write", {63'd0, fb_we}, 64'd0);
      else check("fb_write", {fb_wbank, fb_waddr, fb_wdata}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset_b && b_we) begin
      b_writes++;
      b_last = {b_wbank, b_waddr, b_wdata};
    end
  end

  // One pixel for one cycle; the model decides accept/clip/drop.
  task automatic drive_pix(input logic en, input logic [31:0] x, input logic [31:0] y,
                           input logic [8:0] c, input logic sw);
    draw_en = en; draw_x = x; draw_y = y; draw_color = {23'd0, c}; swap_req = sw;
    if (en) begin
      if (!m_accept) m_drop++;
      else if (x < W && y < H) exp_q.push_back({~m_front, 17'(int'(y) * W + int'(x)), c});
      else m_clip++;
    end
    @(posedge clk); #1;
    draw_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic push_clear(input bit bank);
    for (int a = 0; a < NPIX; a++) exp_q.push_back({bank, 17'(a), 9'h000});
  endtask

  function automatic logic [31:0] rand_coord(input int lim);
    int r = $urandom_range(0, 9);
    if (r == 7) return $urandom_range(lim, lim + 80);
    if (r == 8) return 32'hFFFF_FFFF - $urandom_range(0, 10);
    return $urandom_range(0, lim - 1);
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1; reset_b = 1'b1;
    draw_x = '0; draw_y = '0; draw_color = '0; draw_en = 1'b0; swap_req = 1'b0; vblank = 1'b0;
    bx = '0; by = '0; bcolor = '0; ben = 1'b0; bswap = 1'b0; bvblank = 1'b0;
    m_front = 1'b0; m_accept = 1'b1; m_clip = 0; m_drop = 0; b_writes = 0; b_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", fb_we, 0);
    check("rst_waddr", fb_waddr, 0);
    check("rst_wdata", fb_wdata, 0);
    check("rst_wbank", fb_wbank, 1);
    check("rst_front", front_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip_count, 0);
    check("rst_drop", drop_count, 0);
    @(posedge clk); #1;
    reset = 1'b0; reset_b = 1'b0;

    fork
      begin : main_thread
        // Two-cycle latency of a single pixel.
        drive_pix(1'b1, 32'd5, 32'd2, 9'h1A5, 1'b0);
        @(negedge clk);
        check("lat1_we", fb_we, 0);
        @(negedge clk);
        check("lat2_we", fb_we, 1);
        check("lat2_addr", fb_waddr, 645);
        check("lat2_data", fb_wdata, 9'h1A5);
        check("lat2_bank", fb_wbank, 1);
        @(posedge clk); #1;

        // Frame corners and wrapped coordinates.
        drive_pix(1'b1, 32'd319, 32'd239, 9'h0F0, 1'b0);
        drive_pix(1'b1, 32'd320, 32'd0, 9'h00F, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("clip_edge", clip_count, 1);
        drive_pix(1'b1, 32'hFFFF_FFFE, 32'd5, 9'h111, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("clip_wrap", clip_count, 2);

        // Random stream through the clip and address rules.
        for (int i = 0; i < 400; i++)
          drive_pix($urandom_range(0, 3) != 0, rand_coord(W), rand_coord(H),
                    9'($urandom), 1'b0);
        repeat (4) @(posedge clk); #1;
        check("rand_clip", clip_count, 16'(m_clip));
        check("rand_drop", drop_count, 0);
        check("rand_drained", exp_q.size(), 0);

        // Swap, then reset in the middle of the clear.
        m_accept = 1'b0;
        drive_pix(1'b0, 32'd0, 32'd0, 9'h0, 1'b1);
        push_clear(m_front);
        vblank = 1'b1;
        repeat (3) @(posedge clk); #1;
        vblank = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
          @(negedge clk);
          if (fb_we && fb_waddr == 17'd1000) found = 1'b1;
        end
        check("clear_reach_1000", found, 1);
        check("clear_front_pre", front_sel, 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("abort_we", fb_we, 0);
        check("abort_front", front_sel, 0);
        check("abort_busy", busy, 0);
        check("abort_clip", clip_count, 0);
        @(negedge clk);
        check("abort_we_next", fb_we, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_front = 1'b0; m_accept = 1'b1; m_clip = 0; m_drop = 0;

        // Full swap with a pixel in the request cycle, drops and a complete clear.
        drive_pix(1'b1, 32'd10, 32'd20, 9'h07E, 1'b1);
        m_accept = 1'b0;
        push_clear(m_front);
        vblank = 1'b1;
        for (int i = 0; i < 10; i++)
          drive_pix(1'b1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 9'($urandom), 1'b0);
        vblank = 1'b0;
        check("swap_front", front_sel, 1);
        check("swap_busy", busy, 1);
        found = 1'b0;
        for (int i = 0; i < 80000 && !found; i++) begin
          @(negedge clk);
          if (!busy) found = 1'b1;
        end
        check("clear_done", found, 1);
        check("clear_all_written", exp_q.size(), 0);
        check("drop_after_clear", drop_count, 16'(m_drop));
        check("clip_after_clear", clip_count, 0);
        check("post_front", front_sel, 1);
        m_front = 1'b1; m_accept = 1'b1;
        @(posedge clk); #1;
        drive_pix(1'b1, 32'd7, 32'd3, 9'h155, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("post_write_drained", exp_q.size(), 0);
      end

      begin : small_thread
        // Pixel with the swap request, then a long drop run while no vblank.
        bx = 32'd3; by = 32'd2; bcolor = 32'h0AA; ben = 1'b1; bswap = 1'b1;
        @(posedge clk); #1;
        bswap = 1'b0;
        bx = 32'd1; by = 32'd1;
        repeat (65534) @(posedge clk);
        #1;
        check("b_drop_fffe", b_drop, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        ben = 1'b0;
        check("b_drop_sat", b_drop, 16'hFFFF);
        check("b_writes_wait", b_writes, 1);
        check("b_first_write", b_last, {1'b1, 7'd35, 9'h0AA});
        check("b_busy_wait", b_busy, 1);
        check("b_front_wait", b_front, 0);
        bvblank = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("b_no_clear_busy", b_busy, 0);
        check("b_front_swapped", b_front, 1);
        bx = 32'd15; by = 32'd7; bcolor = 32'h1FF; ben = 1'b1;
        @(posedge clk); #1;
        ben = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("b_writes_total", b_writes, 2);
        check("b_post_write", b_last, {1'b0, 7'd127, 9'h1FF});
        check("b_clip", b_clip, 0);
      end
    join

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
